// File: rtl/level_meter_if.sv
// Sample-in / level-out bundle between a sample source and level_meter.
// The master drives samples and observes the display strobe, level and clip.
interface level_meter_if #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int IN_WIDTH     = 8
);
  logic                    in_valid;
  logic [SAMPLE_WIDTH-1:0] sample;
  logic                    en;
  logic [IN_WIDTH-1:0]     data;
  logic                    clip;

  modport master (output in_valid, sample, input en, data, clip);
  modport slave  (input in_valid, sample, output en, data, clip);
endinterface

// File: rtl/level_meter.sv
// Peak-hold level meter with linear decay feeding an LED bar display.
// Optional clip indicator is built only when LEVEL_METER_CLIP_EN is defined.
module level_meter #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int IN_WIDTH     = 8,
  parameter int UPDATE_DIV   = 1000,
  parameter int HOLD_UPDATES = 8,
  parameter int DECAY_STEP   = 1
) (
  input  logic         clk,
  input  logic         rst,
  level_meter_if.slave bus
);

  localparam int MAG_W  = SAMPLE_WIDTH - 1;
  localparam int CNT_W  = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int HOLD_W = (HOLD_UPDATES > 0) ? $clog2(HOLD_UPDATES + 1) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(UPDATE_DIV - 1);
  localparam logic [HOLD_W-1:0]   HOLD_LOAD = HOLD_W'(HOLD_UPDATES);
  localparam logic [IN_WIDTH-1:0] STEP      = IN_WIDTH'(DECAY_STEP);

  localparam logic [0:0] ST_DECAY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [SAMPLE_WIDTH-1:0] neg_sample;
  logic [MAG_W-1:0]        mag;
  logic [IN_WIDTH-1:0]     lvl;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tick;
  logic [0:0]          state_q, state_d;
  logic [IN_WIDTH-1:0] peak_q, peak_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                capture;
  logic                en_q, en_d;
  logic [IN_WIDTH-1:0] data_q, data_d;

  // Negating the most-negative code leaves the sign bit set; that case saturates.
  always_comb begin
    neg_sample = -bus.sample;
    if (bus.sample[SAMPLE_WIDTH-1]) begin
      if (neg_sample[SAMPLE_WIDTH-1]) begin
        mag = '1;
      end else begin
        mag = neg_sample[MAG_W-1:0];
      end
    end else begin
      mag = bus.sample[MAG_W-1:0];
    end
    lvl = IN_WIDTH'(mag >> (MAG_W - IN_WIDTH));
  end

  assign tick    = (cnt_q == CNT_LAST);
  assign cnt_d   = tick ? '0 : cnt_q + 1'b1;
  assign capture = bus.in_valid && (lvl >= peak_q);

  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    if (capture) begin
      // A capture on a tick cycle swallows that tick's hold/decay step.
      peak_d  = lvl;
      hold_d  = HOLD_LOAD;
      state_d = ST_HOLD;
    end else if (tick) begin
      if (state_q == ST_HOLD) begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end
        if (hold_q <= 1) begin
          state_d = ST_DECAY;
        end
      end else begin
        peak_d = (peak_q > STEP) ? peak_q - STEP : '0;
      end
    end
  end

  assign en_d   = tick;
  assign data_d = tick ? peak_d : data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      state_q <= ST_DECAY;
      peak_q  <= '0;
      hold_q  <= '0;
      en_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  assign bus.en   = en_q;
  assign bus.data = data_q;

`ifdef LEVEL_METER_CLIP_EN
  localparam logic [SAMPLE_WIDTH-1:0] MAX_POS  = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  logic              clip_event;
  logic              clip_q, clip_d;
  logic [HOLD_W-1:0] clip_cnt_q, clip_cnt_d;

  assign clip_event = bus.in_valid && ((bus.sample == MAX_POS) || (bus.sample == MOST_NEG));

  always_comb begin
    clip_d     = clip_q;
    clip_cnt_d = clip_cnt_q;
    if (clip_event) begin
      clip_d     = 1'b1;
      clip_cnt_d = HOLD_LOAD;
    end else if (tick && (clip_cnt_q != '0)) begin
      clip_cnt_d = clip_cnt_q - 1'b1;
      if (clip_cnt_q == 1) begin
        clip_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clip_q     <= 1'b0;
      clip_cnt_q <= '0;
    end else begin
      clip_q     <= clip_d;
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign bus.clip = clip_q;
`else
  assign bus.clip = 1'b0;
`endif

endmodule

// File: tb/tb_level_meter.sv
// Scoreboard bench for level_meter: stimulus queues expected strobe levels,
// a negedge monitor pops and compares them whenever en is seen high.
module tb_level_meter;

  localparam bit CLIP_ON =
`ifdef LEVEL_METER_CLIP_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  level_meter_if #(.SAMPLE_WIDTH(12), .IN_WIDTH(8)) bus_if ();

  level_meter #(
    .SAMPLE_WIDTH(12),
    .IN_WIDTH    (8),
    .UPDATE_DIV  (4),
    .HOLD_UPDATES(2),
    .DECAY_STEP  (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst === 1'b1 && bus_if.en === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got data %02h with no expectation queued", bus_if.data);
      end else begin
        e = exp_q.pop_front();
        $display("strobe %0d data=%02h expected=%02h clip=%0b", strobes, bus_if.data, e, bus_if.clip);
        check("strobe_data", 32'(bus_if.data), 32'(e));
      end
    end
  end

  // One update period, starting at the negedge where the tick count is 0.
  // smp packs slot samples {s3,s2,s1,s0}; exp_c = {clip after slot 0, clip after tick}.
  task automatic run_period(input logic [3:0] vm, input logic [47:0] smp,
                            input logic [7:0] exp_d, input logic [1:0] exp_c);
    logic [1:0] ec;
    ec = exp_c & {2{CLIP_ON}};
    exp_q.push_back(exp_d);
    for (int s = 0; s < 4; s++) begin
      bus_if.in_valid = vm[s];
      bus_if.sample   = smp[12*s +: 12];
      @(negedge clk);
      if (s == 0) check("clip_mid", 32'(bus_if.clip), 32'(ec[1]));
      if (s < 3)  check("en_idle", 32'(bus_if.en), 32'd0);
    end
    bus_if.in_valid = 1'b0;
    bus_if.sample   = '0;
    check("clip_end", 32'(bus_if.clip), 32'(ec[0]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks so far %0d", checks);
    $fatal(1, "watchdog");
  end

  logic [7:0] t2 [20] = '{8'hFE, 8'hFE, 8'hEE, 8'hDE, 8'hCE, 8'hBE, 8'hAE, 8'h9E, 8'h8E, 8'h7E,
                          8'h6E, 8'h5E, 8'h4E, 8'h3E, 8'h2E, 8'h1E, 8'h0E, 8'h00, 8'h00, 8'h00};
  logic [7:0] t5 [7]  = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hEE, 8'hDE};

  initial begin
    rst = 1'b1;
    bus_if.in_valid = 1'b0;
    bus_if.sample   = '0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_en", 32'(bus_if.en), 32'd0);
    check("reset_data", 32'(bus_if.data), 32'd0);
    check("reset_clip", 32'(bus_if.clip), 32'd0);
    rst = 1'b1;

    // Idle strobes every 4 cycles with level 0.
    for (int i = 0; i < 3; i++) run_period(4'b0000, 48'h0, 8'h00, 2'b00);

    // Single 0x7F0: hold two strobes, decay by 16, saturate at 0.
    // A lower sample (0x100, lvl 0x20) during hold is ignored.
    for (int i = 0; i < 20; i++) begin
      if (i == 0)      run_period(4'b0001, {36'h0, 12'h7F0}, t2[i], 2'b00);
      else if (i == 1) run_period(4'b0010, {24'h0, 12'h100, 12'h0}, t2[i], 2'b00);
      else             run_period(4'b0000, 48'h0, t2[i], 2'b00);
    end

    // Rising samples every cycle; the 0x7F0 lands on the tick cycle.
    run_period(4'b1111, {12'h7F0, 12'h400, 12'h200, 12'h010}, 8'hFE, 2'b00);
    run_period(4'b0000, 48'h0, 8'hFE, 2'b00);
    run_period(4'b0000, 48'h0, 8'hFE, 2'b00);
    run_period(4'b0000, 48'h0, 8'hEE, 2'b00);

    // Re-peak on the tick cycle of the strobe that would have shown 0xEE.
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      run_period(4'b0001, {36'h0, 12'h7F0}, t5[i], 2'b00);
      else if (i == 2) run_period(4'b1000, {12'h7F0, 36'h0}, t5[i], 2'b00);
      else             run_period(4'b0000, 48'h0, t5[i], 2'b00);
    end

    // Clip on most-negative, then on max-positive.
    run_period(4'b0001, {36'h0, 12'h800}, 8'hFF, 2'b11);
    run_period(4'b0000, 48'h0, 8'hFF, 2'b10);
    run_period(4'b0000, 48'h0, 8'hEF, 2'b00);
    run_period(4'b0001, {36'h0, 12'h7FF}, 8'hFF, 2'b11);

    // Asynchronous reset mid-period while en, data and clip are active.
    #2 rst = 1'b0;
    #1;
    check("async_rst_en", 32'(bus_if.en), 32'd0);
    check("async_rst_data", 32'(bus_if.data), 32'd0);
    check("async_rst_clip", 32'(bus_if.clip), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) run_period(4'b0000, 48'h0, 8'h00, 2'b00);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_meter.md
# level_meter

Upstream feeder for the LED bar display. Converts a stream of signed audio/sensor samples into an unsigned peak level with peak-hold and linear decay. Emits a periodic update strobe plus level word that connect directly to the bar display's `en`/`data` inputs. Optional clip indicator for a separate LED.

## Interface

**Parameters**
- `SAMPLE_WIDTH`, default 12: signed input sample width. Must satisfy `SAMPLE_WIDTH-1 >= IN_WIDTH`.
- `IN_WIDTH`, default 8: level word width; matches the bar display input width.
- `UPDATE_DIV`, default 1000: clock cycles between update strobes; minimum 2.
- `HOLD_UPDATES`, default 8: update ticks a new peak is held before decay starts; minimum 1.
- `DECAY_STEP`, default 1: level subtracted per update tick while decaying.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous, active-low.
- `in_valid` in 1: sample strobe.
- `sample` in `SAMPLE_WIDTH`: two's-complement sample, qualified by `in_valid`.
- `en` out 1: one-cycle update strobe to the bar display.
- `data` out `IN_WIDTH`: current level, unsigned; held stable between strobes.
- `clip` out 1: clip indicator; see Configuration.

## Operation

**Magnitude**
- mag = |sample|, `SAMPLE_WIDTH-1` bits.
- Most-negative input saturates to all-ones.
- Scaled level lvl = mag[`SAMPLE_WIDTH-2` -: `IN_WIDTH`] (top bits; truncate, no rounding).

**Tick counter**
- Counts 0..`UPDATE_DIV`-1, then wraps.
- tick = (count == `UPDATE_DIV`-1).

**Peak register** `peak` (`IN_WIDTH` bits) and hold counter `hold_cnt`.
- Two states: HOLD and DECAY. Reset state is DECAY with `peak`=0.
- Capture: `in_valid` && lvl >= `peak` → `peak`<=lvl, `hold_cnt`<=`HOLD_UPDATES`, state<=HOLD. Applies in any state, and on tick cycles.
- An equal-level sample reloads the hold. A lower sample is ignored.
- HOLD on tick, no capture: `hold_cnt`-1; when it reaches 0, state<=DECAY.
- DECAY on tick, no capture: `peak`<=max(`peak`-`DECAY_STEP`, 0). Saturates at 0 and never wraps. Remains in DECAY at 0.
- Capture and tick in the same cycle: capture wins and that tick's hold/decay step is suppressed. `en` still fires, with the captured value.

**Output**
- On the tick cycle's edge: `data`<=`peak` next-state value and `en`<=1. Otherwise `en`<=0.
- `data` changes only together with `en`.

**Reset**
- Asserting `rst` (low) at any time immediately clears: `en`=0, `data`=0, `clip`=0, `peak`=0, `hold_cnt`=0, tick count=0, state=DECAY.
- Any in-progress hold is discarded.

## Timing

- First `en` comes `UPDATE_DIV` cycles after the first rising edge with `rst` high. After that, `en` pulses every `UPDATE_DIV` cycles, exactly one cycle wide.
- Sample-to-display latency is up to `UPDATE_DIV` cycles. A sample accepted in the tick cycle itself appears at that cycle's `en`.
- Hold duration: `HOLD_UPDATES` strobes show the held peak, including the strobe that first shows it. The first decrement appears on strobe `HOLD_UPDATES`+1.
- `in_valid` may be asserted every cycle; there is no backpressure.
- All outputs are registered.

## Configuration

**`LEVEL_METER_CLIP_EN`**
- Defined:
  - Clip event = `in_valid` with sample equal to the max positive or most-negative code.
  - A clip event sets `clip`=1 on the next edge and loads a clip counter with `HOLD_UPDATES`.
  - Each tick with no new clip event decrements the counter; `clip` clears on the edge where it reaches 0.
  - A new clip event reloads the counter.
- Undefined: `clip` is tied to 0 and no clip logic is generated.

## Test plan

Bench parameters: `SAMPLE_WIDTH`=12, `IN_WIDTH`=8, `UPDATE_DIV`=4, `HOLD_UPDATES`=2, `DECAY_STEP`=16, `LEVEL_METER_CLIP_EN` defined.

1. Release reset, no samples → `en` pulses at cycles 4, 8, 12… with `data`=0x00. Drop `rst` mid-period → `en`, `data`, `clip` go 0 asynchronously, before the next edge.
2. Single sample 0x7F0 (mag 0x7F0, lvl 0xFE) → strobes show 0xFE, 0xFE, 0xEE, 0xDE, …, 0x0E, 0x00, then 0x00 steady (no wrap).
3. Sample 0x800 (-2048) → lvl 0xFF and `clip`=1 next cycle. `clip` stays 1 through 2 ticks, then clears. Repeat with 0x7FF → same behaviour.
4. During HOLD at 0xFE, send sample 0x100 (lvl 0x20) → ignored; the hold/decay sequence is unchanged.
5. Sample 0x7F0 exactly on the tick cycle of the strobe that would show 0xEE → that strobe shows 0xFE and the hold restarts for 2 strobes.
6. Back-to-back `in_valid` every cycle with rising values 0x010→0x7F0 → the next strobe shows 0xFE, the maximum of the period.
